// File: rtl/ringcounter_pkg.sv
// Shared constants for the ring counter tile: ring width, reset pattern and ui_in control bit map.
package ringcounter_pkg;

  localparam int RING_W = 8;
  localparam logic [RING_W-1:0] RESET_PATTERN = 8'h01;

  localparam int HOLD_BIT = 0;
  localparam int DIR_BIT  = 1;
  localparam int LOAD_BIT = 2;

  function automatic logic is_onehot(input logic [RING_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < RING_W; i++) begin
      if (v[i]) cnt = cnt + 1;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/ring_core.sv
// Ring register, step prescaler and next-state logic (priority: reset > load > hold > step).
// Optional RINGCOUNTER_SELF_CORRECT_EN: a step from a non-one-hot ring restarts at RESET_PATTERN.
module ring_core
  import ringcounter_pkg::*;
#(
  parameter int PRESCALE_W = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              dir,
  input  logic              load,
  input  logic [RING_W-1:0] load_val,
  output logic [RING_W-1:0] ring
);

  // A zero-width prescaler still gets a 1-bit register; tick ignores it in that case.
  localparam int CW = (PRESCALE_W > 0) ? PRESCALE_W : 1;

  logic [CW-1:0]     presc_q, presc_d;
  logic [RING_W-1:0] ring_q, ring_d, rot;
  logic              tick;

  generate
    if (PRESCALE_W == 0) begin : g_no_presc
      assign tick = 1'b1;
    end else begin : g_presc
      assign tick = (presc_q == {CW{1'b1}});
    end
  endgenerate

  always_comb begin
    ring_d  = ring_q;
    presc_d = presc_q;
    rot     = dir ? {ring_q[0], ring_q[RING_W-1:1]}
                  : {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    if (load) begin
      ring_d  = load_val;
      presc_d = '0;
    end else if (!hold) begin
      presc_d = presc_q + CW'(1);
      if (tick) begin
`ifdef RINGCOUNTER_SELF_CORRECT_EN
        ring_d = is_onehot(ring_q) ? rot : RESET_PATTERN;
`else
        ring_d = rot;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q  <= RESET_PATTERN;
      presc_q <= '0;
    end else begin
      ring_q  <= ring_d;
      presc_q <= presc_d;
    end
  end

  assign ring = ring_q;

endmodule

// File: rtl/tt_um_ringcounter.sv
// Tiny Tapeout tile wrapper: maps pins onto ring_core; uio pins are inputs only.
// rst_n keeps the template name but is an active-high synchronous reset.
module tt_um_ringcounter
  import ringcounter_pkg::*;
#(
  parameter int PRESCALE_W = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3]};

  ring_core #(
    .PRESCALE_W(PRESCALE_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst_n),
    .hold    (ui_in[HOLD_BIT]),
    .dir     (ui_in[DIR_BIT]),
    .load    (ui_in[LOAD_BIT]),
    .load_val(uio_in),
    .ring    (uo_out)
  );

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_ringcounter.sv
// Directed bench for tt_um_ringcounter; a second instance with PRESCALE_W=2 covers the prescaler.
module tb_tt_um_ringcounter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out_p, uio_out_p, uio_oe_p;

  int vectors = 0;
  int miscompares = 0;

  always #50 clk = ~clk;

  tt_um_ringcounter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_ringcounter #(.PRESCALE_W(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out_p), .uio_in(uio_in), .uio_out(uio_out_p), .uio_oe(uio_oe_p)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] left_seq [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    rst_n = 1'b1; ui_in = 8'h00; ena = 1'b0; uio_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (uo_out !== 8'h01) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: uo_out=%02h expected 01", i, uo_out);
      end
    end
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vectors++;
      if (uo_out !== left_seq[i] || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        miscompares++;
        $display("FAIL left_step[%0d]: uo_out=%02h uio_out=%02h uio_oe=%02h expected %02h 00 00",
                 i, uo_out, uio_out, uio_oe, left_seq[i]);
      end
    end
  endtask

  task automatic test_direction();
    logic [7:0] right_seq [12] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                   8'h80, 8'h40, 8'h20, 8'h10};
    ena = 1'b1;
    ui_in = 8'h02;
    for (int i = 0; i < 12; i++) begin
      cycle();
      vectors++;
      if (uo_out !== right_seq[i]) begin
        miscompares++;
        $display("FAIL right_step[%0d]: uo_out=%02h expected %02h", i, uo_out, right_seq[i]);
      end
    end
    ui_in = 8'hF8;
    cycle();
    vectors++;
    if (uo_out !== 8'h20) begin
      miscompares++;
      $display("FAIL dir_switch: uo_out=%02h expected 20", uo_out);
    end
  endtask

  task automatic test_hold_reset();
    logic [7:0] pre [3] = '{8'h02, 8'h04, 8'h08};
    rst_n = 1'b1; ui_in = 8'h00;
    cycle();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (uo_out !== pre[i]) begin
        miscompares++;
        $display("FAIL pre_hold[%0d]: uo_out=%02h expected %02h", i, uo_out, pre[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      ui_in = (i % 2 == 0) ? 8'h01 : 8'hF9;
      ena = i[0];
      cycle();
      vectors++;
      if (uo_out !== 8'h08) begin
        miscompares++;
        $display("FAIL hold[%0d]: uo_out=%02h expected 08", i, uo_out);
      end
    end
    ui_in = 8'h00;
    cycle();
    vectors++;
    if (uo_out !== 8'h10) begin
      miscompares++;
      $display("FAIL resume: uo_out=%02h expected 10", uo_out);
    end
    cycle();
    vectors++;
    if (uo_out !== 8'h20) begin
      miscompares++;
      $display("FAIL resume2: uo_out=%02h expected 20", uo_out);
    end
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (uo_out !== 8'h01) begin
      miscompares++;
      $display("FAIL mid_reset: uo_out=%02h expected 01", uo_out);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; ui_in = 8'h04; uio_in = 8'hA5;
    cycle();
    vectors++;
    if (uo_out !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_over_load: uo_out=%02h expected 01", uo_out);
    end
    rst_n = 1'b0; ui_in = 8'h00;
  endtask

  task automatic test_load();
`ifdef RINGCOUNTER_SELF_CORRECT_EN
    logic [7:0] after_a5 [2] = '{8'h01, 8'h02};
    logic [7:0] after_03 = 8'h01;
`else
    logic [7:0] after_a5 [2] = '{8'h4B, 8'h96};
    logic [7:0] after_03 = 8'h06;
`endif
    uio_in = 8'hA5; ui_in = 8'h07;
    cycle();
    vectors++;
    if (uo_out !== 8'hA5) begin
      miscompares++;
      $display("FAIL load_a5: uo_out=%02h expected a5", uo_out);
    end
    ui_in = 8'h00; uio_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (uo_out !== after_a5[i]) begin
        miscompares++;
        $display("FAIL after_load[%0d]: uo_out=%02h expected %02h", i, uo_out, after_a5[i]);
      end
    end
    uio_in = 8'h03; ui_in = 8'h04;
    cycle();
    vectors++;
    if (uo_out !== 8'h03) begin
      miscompares++;
      $display("FAIL load_03: uo_out=%02h expected 03", uo_out);
    end
    ui_in = 8'h00;
    cycle();
    vectors++;
    if (uo_out !== after_03) begin
      miscompares++;
      $display("FAIL step_03: uo_out=%02h expected %02h", uo_out, after_03);
    end
  endtask

  task automatic test_zero();
`ifdef RINGCOUNTER_SELF_CORRECT_EN
    logic [7:0] zseq [3] = '{8'h01, 8'h02, 8'h04};
`else
    logic [7:0] zseq [3] = '{8'h00, 8'h00, 8'h00};
`endif
    uio_in = 8'h00; ui_in = 8'h04;
    cycle();
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL load_zero: uo_out=%02h expected 00", uo_out);
    end
    ui_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (uo_out !== zseq[i]) begin
        miscompares++;
        $display("FAIL zero_run[%0d]: uo_out=%02h expected %02h", i, uo_out, zseq[i]);
      end
    end
  endtask

  task automatic test_prescaler();
    // Edges after reset: steps land on 4 and 8; a 3-cycle hold pushes the next one from 12 to 15.
    logic [7:0] pseq [15] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04,
                              8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h08};
    rst_n = 1'b1; ui_in = 8'h00;
    cycle();
    vectors++;
    if (uo_out_p !== 8'h01 || uio_out_p !== 8'h00 || uio_oe_p !== 8'h00) begin
      miscompares++;
      $display("FAIL presc_reset: uo_out=%02h uio_out=%02h uio_oe=%02h expected 01 00 00",
               uo_out_p, uio_out_p, uio_oe_p);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ui_in = (i >= 8 && i <= 10) ? 8'h01 : 8'h00;
      cycle();
      vectors++;
      if (uo_out_p !== pseq[i]) begin
        miscompares++;
        $display("FAIL presc_edge[%0d]: uo_out=%02h expected %02h", i + 1, uo_out_p, pseq[i]);
      end
    end
    uio_in = 8'h10; ui_in = 8'h04;
    cycle();
    ui_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (uo_out_p !== ((i == 3) ? 8'h20 : 8'h10)) begin
        miscompares++;
        $display("FAIL presc_after_load[%0d]: uo_out=%02h expected %02h",
                 i, uo_out_p, (i == 3) ? 8'h20 : 8'h10);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    test_reset();
    test_direction();
    test_hold_reset();
    test_load();
    test_zero();
    test_prescaler();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
